led_flow_ctrl: RTL and testbench

//  Consumer of the 1 Hz divider square wave (clk_1hz_out) in the LED-flow design.

---
 rtl/led_flow_ctrl_pkg.sv | 34 +++
 rtl/rise_edge_det.sv | 22 ++
 rtl/led_flow_ctrl.sv | 128 ++++++++++++
 tb/tb_led_flow_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/led_flow_ctrl_pkg.sv
// led_flow_ctrl_pkg: state/mode encodings, LED count default and one-hot helper. Rev 1.0
`default_nettype none

package led_flow_ctrl_pkg;

  localparam int LED_NUM_DEFAULT = 8;

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_PP    = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_PP    = 2'd3
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Clearing the lowest set bit leaves zero only for exactly one set bit.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_edge_det.sv
// rise_edge_det: one-cycle pulse on a 0->1 level transition; history resets high. Rev 1.0
`default_nettype none

module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b1;
    else        level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

`default_nettype wire

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: one-hot LED pattern stepped on each 1 Hz rising edge. Rev 1.0
// Optional ping-pong mode is built when LED_FLOW_PINGPONG_EN is defined.
`default_nettype none

module led_flow_ctrl
  import led_flow_ctrl_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_1hz_in,
  input  logic               run,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] led,
  output logic               step,
  output logic               wrap
);

  logic               tick;
  state_e             state, state_nxt;
  logic [LED_NUM-1:0] led_nxt;
  logic               step_nxt, wrap_nxt;
`ifdef LED_FLOW_PINGPONG_EN
  dir_e               dir, dir_nxt;
`endif

  rise_edge_det u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .level (clk_1hz_in),
    .pulse (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_PAUSE;
      led   <= {{(LED_NUM-1){1'b0}}, 1'b1};
      step  <= 1'b0;
      wrap  <= 1'b0;
`ifdef LED_FLOW_PINGPONG_EN
      dir   <= DIR_UP;
`endif
    end else begin
      state <= state_nxt;
      led   <= led_nxt;
      step  <= step_nxt;
      wrap  <= wrap_nxt;
`ifdef LED_FLOW_PINGPONG_EN
      dir   <= dir_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = ST_PAUSE;
    led_nxt   = led;
    step_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
`ifdef LED_FLOW_PINGPONG_EN
    dir_nxt   = dir;
`endif

    if (run) begin
      case (mode)
        MODE_RIGHT: state_nxt = ST_RIGHT;
        MODE_HOLD:  state_nxt = ST_PAUSE;
`ifdef LED_FLOW_PINGPONG_EN
        MODE_PP:    state_nxt = ST_PP;
`endif
        default:    state_nxt = ST_LEFT;
      endcase
    end

`ifdef LED_FLOW_PINGPONG_EN
    // Arriving at the top end means the only way forward is down.
    if (state_nxt == ST_PP && state != ST_PP)
      dir_nxt = led[LED_NUM-1] ? DIR_DOWN : DIR_UP;
`endif

    // The move is decided by the registered state, so a same-cycle mode change waits a tick.
    if (tick && state != ST_PAUSE) begin
      step_nxt = 1'b1;
      if (!is_onehot(32'(led))) begin
        led_nxt = {{(LED_NUM-1){1'b0}}, 1'b1};
      end else begin
        case (state)
          ST_LEFT: begin
            led_nxt  = {led[LED_NUM-2:0], led[LED_NUM-1]};
            wrap_nxt = led[LED_NUM-1];
          end
          ST_RIGHT: begin
            led_nxt  = {led[0], led[LED_NUM-1:1]};
            wrap_nxt = led[0];
          end
`ifdef LED_FLOW_PINGPONG_EN
          ST_PP: begin
            if (dir == DIR_UP) begin
              if (led[LED_NUM-1]) begin
                led_nxt  = led >> 1;
                dir_nxt  = DIR_DOWN;
                wrap_nxt = 1'b1;
              end else begin
                led_nxt  = led << 1;
              end
            end else begin
              if (led[0]) begin
                led_nxt  = led << 1;
                dir_nxt  = DIR_UP;
                wrap_nxt = 1'b1;
              end else begin
                led_nxt  = led >> 1;
              end
            end
          end
`endif
          default: begin
            led_nxt  = led;
            step_nxt = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: directed checks of led_flow_ctrl with LED_NUM=8. Rev 1.0
`default_nettype none

module tb_led_flow_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clk_1hz_in;
  logic       run;
  logic [1:0] mode;
  logic [7:0] led;
  logic       step;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  logic [7:0]  pp_led [15];
  logic [14:0] pp_wrap;

  led_flow_ctrl #(.LED_NUM(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_1hz_in (clk_1hz_in),
    .run        (run),
    .mode       (mode),
    .led        (led),
    .step       (step),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: raises the 1 Hz input, checks the result one edge later,
  // checks the pulses have dropped, then completes a 20-cycle square-wave period.
  task automatic tick_chk(input string tag, input logic [7:0] exp_led,
                          input logic exp_step, input logic exp_wrap);
    clk_1hz_in = 1'b1;
    @(negedge clk);
    check({tag, "_led"},  32'(led),  32'(exp_led));
    check({tag, "_step"}, 32'(step), 32'(exp_step));
    check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
    @(negedge clk);
    check({tag, "_step_off"}, 32'(step), 32'd0);
    check({tag, "_wrap_off"}, 32'(wrap), 32'd0);
    repeat (8) @(negedge clk);
    clk_1hz_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
`ifdef LED_FLOW_PINGPONG_EN
    pp_led  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    pp_wrap = 15'b100_0000_1000_0000;
`else
    pp_led  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    pp_wrap = 15'b000_0000_1000_0000;
`endif

    // Reset with the 1 Hz input already high: no step at release.
    rst_n = 1'b0; clk_1hz_in = 1'b1; run = 1'b1; mode = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_led",  32'(led),  32'h01);
    check("rst_step", 32'(step), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("hi_at_release_led",  32'(led),  32'h01);
    check("hi_at_release_step", 32'(step), 32'd0);
    clk_1hz_in = 1'b0;
    repeat (10) @(negedge clk);

    // Rotate left through a full lap.
    tick_chk("l1", 8'h02, 1'b1, 1'b0);
    tick_chk("l2", 8'h04, 1'b1, 1'b0);
    tick_chk("l3", 8'h08, 1'b1, 1'b0);
    tick_chk("l4", 8'h10, 1'b1, 1'b0);
    tick_chk("l5", 8'h20, 1'b1, 1'b0);
    tick_chk("l6", 8'h40, 1'b1, 1'b0);
    tick_chk("l7", 8'h80, 1'b1, 1'b0);
    tick_chk("l8", 8'h01, 1'b1, 1'b1);

    // Rotate right wraps from bit 0 to the top.
    mode = 2'b01;
    repeat (2) @(negedge clk);
    tick_chk("r1", 8'h80, 1'b1, 1'b1);
    tick_chk("r2", 8'h40, 1'b1, 1'b0);
    mode = 2'b00;
    repeat (2) @(negedge clk);
    tick_chk("l9",  8'h80, 1'b1, 1'b0);
    tick_chk("l10", 8'h01, 1'b1, 1'b1);

    // Ping-pong (or plain left rotation without the option).
    mode = 2'b10;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 15; i++)
      tick_chk($sformatf("pp%0d", i), pp_led[i], 1'b1, pp_wrap[i]);

    // Asynchronous reset in the middle of a clock period.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led",  32'(led),  32'h01);
    check("async_rst_step", 32'(step), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 2'b00;
    repeat (4) @(negedge clk);

    // Freeze with run=0, then with mode=11.
    tick_chk("f0", 8'h02, 1'b1, 1'b0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    tick_chk("run0_a", 8'h02, 1'b0, 1'b0);
    tick_chk("run0_b", 8'h02, 1'b0, 1'b0);
    tick_chk("run0_c", 8'h02, 1'b0, 1'b0);
    run = 1'b1;
    repeat (2) @(negedge clk);
    tick_chk("resume1", 8'h04, 1'b1, 1'b0);
    mode = 2'b11;
    repeat (2) @(negedge clk);
    tick_chk("hold_a", 8'h04, 1'b0, 1'b0);
    tick_chk("hold_b", 8'h04, 1'b0, 1'b0);
    tick_chk("hold_c", 8'h04, 1'b0, 1'b0);
    mode = 2'b00;
    repeat (2) @(negedge clk);
    tick_chk("resume2", 8'h08, 1'b1, 1'b0);

    // Mode change on the tick cycle moves with the old direction.
    mode = 2'b01;
    tick_chk("chg_old", 8'h10, 1'b1, 1'b0);
    tick_chk("chg_new", 8'h08, 1'b1, 1'b0);

    // Corrupt patterns recover to bit 0 without wrap.
    force dut.led = 8'h11;
    @(negedge clk);
    release dut.led;
    @(negedge clk);
    tick_chk("multi_hot", 8'h01, 1'b1, 1'b0);
    force dut.led = 8'h00;
    @(negedge clk);
    release dut.led;
    @(negedge clk);
    tick_chk("zero_hot", 8'h01, 1'b1, 1'b0);
    tick_chk("after_fix", 8'h80, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
